// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - shifts bitstream words LSB-first onto the fabric config chain
// Counts chain bits and stops exactly at CHAIN_LEN, discarding any unused upper bits of the last word.
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_loaded
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]  bit_idx, bit_idx_n;
  logic [CNT_W-1:0]  bits_n, bits_inc;
  logic              head_n, en_n;
  logic              last_bit, last_of_word;

  assign bits_inc     = bits_loaded + CNT_W'(1);
  assign last_bit     = (bits_inc == CNT_W'(CHAIN_LEN));
  assign last_of_word = (bit_idx == IDX_W'(WORD_W - 1));

  assign word_ready = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_SHIFT);
  assign done       = (state == S_DONE);

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    bits_n    = bits_loaded;
    head_n    = 1'b0;
    en_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          bits_n  = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (word_valid) begin
          state_n   = S_SHIFT;
          shreg_n   = word_data >> 1;
          head_n    = word_data[0];
          en_n      = 1'b1;
          bit_idx_n = '0;
        end
      end
      S_SHIFT: begin
        // The bit now on ccff_head is captured by the chain at this edge, even when aborting.
        bits_n = bits_inc;
        if (abort) begin
          state_n = S_IDLE;
        end else if (last_bit) begin
          state_n = S_DONE;
        end else if (last_of_word) begin
          state_n = S_LOAD;
        end else begin
          head_n    = shreg[0];
          shreg_n   = shreg >> 1;
          en_n      = 1'b1;
          bit_idx_n = bit_idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          state_n = S_LOAD;
          bits_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      bits_loaded <= '0;
      ccff_head   <= 1'b0;
      ccff_en     <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_idx     <= bit_idx_n;
      bits_loaded <= bits_n;
      ccff_head   <= head_n;
      ccff_en     <= en_n;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - self-checking bench for config_chain_loader
// Expected chain contents come from concatenating the supplied words LSB-first and truncating.
module tb_config_chain_loader;

  localparam int WW = 8;
  localparam int CL = 20;
  localparam int CW = $clog2(CL + 1);

  logic          prog_clk = 1'b0;
  logic          prog_reset, start, abort, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, ccff_head, ccff_en, busy, done;
  logic [CW-1:0] bits_loaded;

  int vecs = 0;
  int errs = 0;

  logic [WW-1:0] words[$];
  int            gaps[$];
  int            abort_at, start_at, exp_bits;
  logic          abort_with_start;
  logic          chain_got[$];

  always #5 prog_clk = ~prog_clk;

  config_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_en(ccff_en), .busy(busy), .done(done),
    .bits_loaded(bits_loaded)
  );

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic set_plan(input int nwords, input int max_gap);
    words.delete();
    gaps.delete();
    for (int k = 0; k < nwords; k++) begin
      words.push_back(WW'($urandom));
      gaps.push_back(int'($urandom_range(max_gap, 0)));
    end
    abort_at = -1;
    start_at = -1;
    abort_with_start = 1'b0;
  endtask

  task automatic do_start(input string tag);
    logic [CW-1:0] eb;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_bits = 0;
    eb = '0;
    vecs++;
    if ({word_ready, ccff_en, busy, done, bits_loaded} !== {1'b1, 1'b0, 1'b1, 1'b0, eb}) begin
      errs++;
      $display("FAIL %s_start rdy/en/busy/done/bits got %b/%b/%b/%b/%0d want 1/0/1/0/0",
               tag, word_ready, ccff_en, busy, done, bits_loaded);
    end
  endtask

  // Feeds the planned words from a LOAD state and checks every cycle's timing.
  task automatic do_load(input string tag);
    logic [CW-1:0] eb;
    logic [WW-1:0] w;
    logic [CL-1:0] gv, ev;
    int            n, exp_len;
    logic          aborted;
    chain_got.delete();
    aborted = 1'b0;
    for (int k = 0; k < words.size() && !aborted && exp_bits < CL; k++) begin
      w = words[k];
      for (int g = 0; g < gaps[k]; g++) begin
        eb = CW'(exp_bits);
        vecs++;
        if ({word_ready, ccff_en, busy, done, bits_loaded} !== {1'b1, 1'b0, 1'b1, 1'b0, eb}) begin
          errs++;
          $display("FAIL %s_gap w%0d rdy/en/busy/done/bits got %b/%b/%b/%b/%0d want 1/0/1/0/%0d",
                   tag, k, word_ready, ccff_en, busy, done, bits_loaded, exp_bits);
        end
        word_valid = 1'b0;
        word_data  = WW'($urandom);
        tick();
      end
      eb = CW'(exp_bits);
      vecs++;
      if ({word_ready, ccff_en, busy, done, bits_loaded} !== {1'b1, 1'b0, 1'b1, 1'b0, eb}) begin
        errs++;
        $display("FAIL %s_wait w%0d rdy/en/busy/done/bits got %b/%b/%b/%b/%0d want 1/0/1/0/%0d",
                 tag, k, word_ready, ccff_en, busy, done, bits_loaded, exp_bits);
      end
      word_valid = 1'b1;
      word_data  = w;
      tick();
      n = (CL - exp_bits < WW) ? CL - exp_bits : WW;
      for (int i = 0; i < n && !aborted; i++) begin
        eb = CW'(exp_bits);
        vecs++;
        if ({word_ready, ccff_en, busy, done, bits_loaded, ccff_head} !==
            {1'b0, 1'b1, 1'b1, 1'b0, eb, w[i]}) begin
          errs++;
          $display("FAIL %s_shift w%0d b%0d rdy/en/busy/done/bits/head got %b/%b/%b/%b/%0d/%b want 0/1/1/0/%0d/%b",
                   tag, k, i, word_ready, ccff_en, busy, done, bits_loaded, ccff_head, exp_bits, w[i]);
        end
        chain_got.push_back(ccff_head);
        word_valid = (k + 1 < words.size()) && (gaps[k + 1] == 0);
        word_data  = WW'($urandom);
        if (exp_bits == abort_at) begin
          abort   = 1'b1;
          start   = abort_with_start;
          aborted = 1'b1;
        end
        if (exp_bits == start_at) start = 1'b1;
        exp_bits++;
        tick();
        abort = 1'b0;
        start = 1'b0;
      end
    end
    word_valid = 1'b0;
    eb = CW'(exp_bits);
    vecs++;
    if ({word_ready, ccff_en, busy, done, bits_loaded} !== {1'b0, 1'b0, 1'b0, !aborted, eb}) begin
      errs++;
      $display("FAIL %s_end rdy/en/busy/done/bits got %b/%b/%b/%b/%0d want 0/0/0/%b/%0d",
               tag, word_ready, ccff_en, busy, done, bits_loaded, !aborted, exp_bits);
    end
    exp_len = (abort_at >= 0) ? abort_at + 1 : ((WW * words.size() < CL) ? WW * words.size() : CL);
    gv = '0;
    ev = '0;
    for (int j = 0; j < chain_got.size() && j < CL; j++) gv[j] = chain_got[j];
    for (int j = 0; j < exp_len; j++) ev[j] = words[j / WW][j % WW];
    vecs++;
    if (chain_got.size() != exp_len || gv !== ev) begin
      errs++;
      $display("FAIL %s_chain got %0d bits %b want %0d bits %b", tag, chain_got.size(), gv, exp_len, ev);
    end
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b1;
    word_data  = WW'($urandom);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if ({word_ready, ccff_en, busy, done, ccff_head, bits_loaded} !== '0) begin
        errs++;
        $display("FAIL reset c%0d rdy/en/busy/done/head/bits got %b/%b/%b/%b/%b/%0d want 0/0/0/0/0/0",
                 c, word_ready, ccff_en, busy, done, ccff_head, bits_loaded);
      end
      prog_reset = 1'b0;
      tick();
    end
    word_valid = 1'b0;
  endtask

  task automatic test_full_load();
    set_plan(3, 0);
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    do_start("full");
    do_load("full");
    // done is sticky and abort after completion is ignored
    for (int c = 0; c < 3; c++) begin
      abort = (c == 1);
      tick();
      vecs++;
      if ({done, busy, word_ready, bits_loaded} !== {1'b1, 1'b0, 1'b0, 5'(CL)}) begin
        errs++;
        $display("FAIL full_sticky c%0d done/busy/rdy/bits got %b/%b/%b/%0d want 1/0/0/%0d",
                 c, done, busy, word_ready, bits_loaded, CL);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_backpressure();
    set_plan(3, 0);
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    gaps[1]  = 5;
    do_start("bp");
    do_load("bp");
  endtask

  task automatic test_abort();
    set_plan(3, 0);
    abort_at = 11;
    do_start("abort");
    do_load("abort");
    tick();
    vecs++;
    if ({word_ready, ccff_en, busy, done, bits_loaded} !== {1'b0, 1'b0, 1'b0, 1'b0, 5'd12}) begin
      errs++;
      $display("FAIL abort_idle rdy/en/busy/done/bits got %b/%b/%b/%b/%0d want 0/0/0/0/12",
               word_ready, ccff_en, busy, done, bits_loaded);
    end
    set_plan(3, 2);
    do_start("abort_again");
    do_load("abort_again");
  endtask

  task automatic test_restart();
    set_plan(3, 3);
    do_start("restart");
    do_load("restart");
  endtask

  task automatic test_simultaneous();
    set_plan(3, 0);
    abort_at = 5;
    abort_with_start = 1'b1;
    do_start("abort_start");
    do_load("abort_start");
    tick();
    vecs++;
    if ({word_ready, busy, done, bits_loaded} !== {1'b0, 1'b0, 1'b0, 5'd6}) begin
      errs++;
      $display("FAIL abort_start_idle rdy/busy/done/bits got %b/%b/%b/%0d want 0/0/0/6",
               word_ready, busy, done, bits_loaded);
    end
    set_plan(3, 1);
    start_at = 9;
    do_start("start_busy");
    do_load("start_busy");
    do_start("reset_mid");
    word_valid = 1'b1;
    word_data  = WW'($urandom);
    repeat (4) tick();
    prog_reset = 1'b1;
    word_valid = 1'b0;
    tick();
    vecs++;
    if ({word_ready, ccff_en, busy, done, ccff_head, bits_loaded} !== '0) begin
      errs++;
      $display("FAIL reset_mid rdy/en/busy/done/head/bits got %b/%b/%b/%b/%b/%0d want 0/0/0/0/0/0",
               word_ready, ccff_en, busy, done, ccff_head, bits_loaded);
    end
    prog_reset = 1'b0;
    tick();
    vecs++;
    if ({word_ready, ccff_en, busy, done, bits_loaded} !== '0) begin
      errs++;
      $display("FAIL reset_mid_idle rdy/en/busy/done/bits got %b/%b/%b/%b/%0d want 0/0/0/0/0",
               word_ready, ccff_en, busy, done, bits_loaded);
    end
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 4; r++) begin
      set_plan(3, 3);
      do_start("rand");
      do_load("rand");
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_restart();
    test_simultaneous();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Sequencer that programs the fabric's configuration chain, the serial string of config flops that drive the select inputs of the routing and LUT multiplexers. It accepts parallel bitstream words over a valid/ready handshake and shifts them LSB-first onto the chain head with a qualifying shift enable. It counts chain bits, stops exactly at the chain length, and then flags completion. It sits between the bitstream source (SPI/JTAG word assembler) and the chain head of the fabric.

## Interface
Parameters:
- WORD_W, 32, bitstream word width (≥2).
- CHAIN_LEN, 1024, total config flops in the chain (≥1). It need not be a multiple of WORD_W.
- CNT_W, $clog2(CHAIN_LEN+1), bit counter width (derived; do not override).

Ports:
- prog_clk  in  1  programming clock. One clock domain: all state changes on the rising edge.
- prog_reset  in  1  reset, synchronous and active-high.
- start  in  1  single-cycle request to begin a load.
- abort  in  1  cancel the load in progress.
- word_data  in  WORD_W  bitstream word. Bit 0 is shifted first.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  loader accepts word_data this cycle.
- ccff_head  out  1  serial config data to the chain head (registered).
- ccff_en  out  1  chain shift enable. Chain flops capture ccff_head at the edge ending any cycle with ccff_en=1 (registered).
- busy  out  1  load in progress (LOAD or SHIFT).
- done  out  1  chain fully loaded. Sticky.
- bits_loaded  out  CNT_W  chain bits shifted so far in this load.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 → LOAD.
  - bits_loaded is cleared to 0 and done to 0.
- LOAD:
  - word_ready=1.
  - On word_valid&word_ready the loader captures the word into the shift register, sets word bit index to 0, and goes to SHIFT.
  - With no valid word the loader waits indefinitely. ccff_en=0 while waiting.
- SHIFT: one chain bit per cycle, word bits 0,1,2,… in order. bits_loaded increments by 1 per bit. word_ready=0.
  - After bit WORD_W-1 is presented, with bits_loaded < CHAIN_LEN → LOAD.
  - When bits_loaded reaches CHAIN_LEN → DONE immediately. This can happen mid-word. The remaining upper bits of the final word are discarded and never appear with ccff_en=1.
- DONE:
  - done=1, busy=0, word_ready=0.
  - bits_loaded holds at CHAIN_LEN.
  - start=1 → restart: bits_loaded and done cleared, → LOAD.
- abort=1 in LOAD or SHIFT:
  - → IDLE next edge. ccff_en=0 from the following cycle.
  - Any partially shifted word is dropped. done stays 0.
  - bits_loaded holds its value until the next start.
  - abort in IDLE/DONE: no effect.
- Priority: abort > start. start in LOAD/SHIFT is ignored.
- ccff_head is don't-care when ccff_en=0, but must be driven to 0 in that case for determinism.

## Timing
- Reset values: word_ready=0, ccff_head=0, ccff_en=0, busy=0, done=0, bits_loaded=0, state IDLE.
- prog_reset asserted mid-load: the reset values above apply at that edge and any partial word is lost.
- start sampled at edge T → word_ready=1 and busy=1 in cycle T+1.
- Word accepted at edge E → word bit i is on ccff_head with ccff_en=1 in cycle E+1+i, for i = 0 … n-1.
  - n = min(WORD_W, CHAIN_LEN − bits_loaded at E).
- Between words:
  - word_ready reasserts in cycle E+1+WORD_W, so there is at least one ccff_en=0 cycle between consecutive words.
  - Full-throughput rate is WORD_W+1 cycles per word.
- Completion: the cycle after the last ccff_en=1 cycle has done=1, busy=0, ccff_en=0. bits_loaded=CHAIN_LEN becomes visible in that same cycle.
- bits_loaded updates at each edge that ends a ccff_en=1 cycle. It never exceeds CHAIN_LEN and never wraps.

## Test plan
Parameters for all scenarios: WORD_W=8, CHAIN_LEN=20.
- Reset/idle:
  - Stimulus: hold prog_reset for 2 cycles, then drive word_valid=1 with no start.
  - Required: all outputs at reset values and word_ready stays 0.
- Full load:
  - Stimulus: start, then words 0xA5, 0x3C, 0xFF with word_valid always 1.
  - Required: exactly 20 ccff_en cycles carrying 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0 / 1,1,1,1. Upper nibble of 0xFF is never shifted.
  - Required: done=1 and bits_loaded=20 one cycle after the last bit. Total of 22 ccff_en=0/1 boundary checks match the E+1+i timing.
- Backpressure:
  - Stimulus: insert 5 idle cycles of word_valid=0 before the second word.
  - Required: word_ready held 1, ccff_en=0 and bits_loaded=8 during the gap. Final chain contents are identical to the full-load scenario.
- Abort mid-word:
  - Stimulus: abort in the cycle bit 3 of word 2 is presented.
  - Required: ccff_en=0 from the next cycle, state IDLE, done=0, bits_loaded=12.
  - Follow-up: new start clears bits_loaded to 0 and a full load then succeeds.
- Restart from DONE:
  - Stimulus: start while done=1.
  - Required: done drops the next cycle, word_ready=1, and a second full load completes.
- Simultaneous events:
  - abort and start in the same cycle during SHIFT → IDLE.
  - start pulse while busy → ignored, with no change to bits_loaded.
  - prog_reset mid-SHIFT → all outputs at reset values on the next cycle.
